// File: rtl/seq_pkg.sv
// Shared definitions for the execute-stage sequencer: state encoding,
// run-mode codes and the default halt opcode.
package seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ARM     = 3'd1,
      ST_RUN     = 3'd2,
      ST_RD_WAIT = 3'd3,
      ST_WR_WAIT = 3'd4
   } seq_state_e;

   localparam logic [1:0]  MODE_FREE   = 2'b00;
   localparam logic [1:0]  MODE_SINGLE = 2'b01;
   localparam logic [1:0]  MODE_NSTEP  = 2'b10;

   localparam logic [15:0] HALT_OPCODE_DEF = 16'h0300;

   function automatic logic is_stepping(input logic [1:0] mode);
      return (mode == MODE_SINGLE) || (mode == MODE_NSTEP);
   endfunction

endpackage

// File: rtl/seq_wait_timer.sv
// Saturating wait-state counter with clear/enable and a minimum-reached
// compare against a caller-supplied limit (minimum cycles minus one).
module seq_wait_timer #(
   parameter int CNT_W = 4
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             clear_i,
   input  logic             enable_i,
   input  logic [CNT_W-1:0] limit_i,
   output logic             reached_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_ff @(posedge clock) begin
      if (!resetn) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i)                       cnt_d = '0;
      else if (enable_i && cnt_q != '1)  cnt_d = cnt_q + CNT_W'(1);
   end

   assign reached_o = (cnt_q >= limit_i);

endmodule

// File: rtl/exec_sequencer.sv
// Execute-stage sequencer: gates PC increment and load source per instruction,
// inserts req/ack memory wait states and provides free/single/N-step run modes.
module exec_sequencer
   import seq_pkg::*;
#(
   parameter int          RD_MIN      = 1,
   parameter int          WR_MIN      = 1,
   parameter int          CNT_W       = 4,
   parameter int          STEP_W      = 8,
   parameter logic [15:0] HALT_OPCODE = HALT_OPCODE_DEF
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic              user_clock,
   input  logic              stop_req,
   input  logic [1:0]        run_mode,
   input  logic [STEP_W-1:0] step_count,
   input  logic [15:0]       current_instruction,
   input  logic [1:0]        dec_load_src,
   input  logic              dec_store,
   input  logic              dec_increment,
   input  logic              mem_ack,
   output logic              program_counter_increment,
   output logic [1:0]        alu_load_src,
   output logic              mem_rd_req,
   output logic              mem_wr_req,
   output logic              running,
   output logic [STEP_W-1:0] steps_left,
   output logic [2:0]        state_dbg
);

   localparam logic [CNT_W-1:0] RD_LIM = CNT_W'(RD_MIN - 1);
   localparam logic [CNT_W-1:0] WR_LIM = CNT_W'(WR_MIN - 1);

   seq_state_e        state_q, state_d;
   logic [STEP_W-1:0] steps_q, steps_d;
   logic              step_mode_q, step_mode_d;
   logic              timer_clear, timer_reached, retire;
   logic              need_rd, need_wr;

   assign need_rd = dec_load_src[1];
   assign need_wr = dec_store;

   seq_wait_timer #(.CNT_W(CNT_W)) u_wait_timer (
      .clock     (clock),
      .resetn    (resetn),
      .clear_i   (timer_clear),
      .enable_i  ((state_q == ST_RD_WAIT) || (state_q == ST_WR_WAIT)),
      .limit_i   ((state_q == ST_WR_WAIT) ? WR_LIM : RD_LIM),
      .reached_o (timer_reached)
   );

   always_ff @(posedge clock) begin
      if (!resetn) begin
         state_q     <= ST_IDLE;
         steps_q     <= '0;
         step_mode_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         steps_q     <= steps_d;
         step_mode_q <= step_mode_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      steps_d     = steps_q;
      step_mode_d = step_mode_q;
      timer_clear = 1'b0;
      case (state_q)
         ST_IDLE: if (!user_clock) state_d = ST_ARM;
         ST_ARM: begin
            if (user_clock) begin
               state_d     = ST_RUN;
               step_mode_d = is_stepping(run_mode);
               case (run_mode)
                  MODE_SINGLE: steps_d = STEP_W'(1);
                  MODE_NSTEP:  steps_d = (step_count == '0) ? STEP_W'(1) : step_count;
                  default:     steps_d = '0;
               endcase
            end
         end
         ST_RUN: begin
            if (need_rd) begin
               state_d     = ST_RD_WAIT;
               timer_clear = 1'b1;
            end else if (need_wr) begin
               state_d     = ST_WR_WAIT;
               timer_clear = 1'b1;
            end
         end
         ST_RD_WAIT: begin
            if (timer_reached && mem_ack && need_wr) begin
               state_d     = ST_WR_WAIT;
               timer_clear = 1'b1;
            end
         end
         default: ;
      endcase
      // Stop and halt are only honoured at instruction boundaries.
      if (retire) begin
         if (step_mode_q && steps_q != '0) steps_d = steps_q - STEP_W'(1);
         if (stop_req || current_instruction == HALT_OPCODE ||
             (step_mode_q && steps_q <= STEP_W'(1)))
            state_d = ST_IDLE;
         else
            state_d = ST_RUN;
      end
   end

   always_comb begin
      retire     = 1'b0;
      mem_rd_req = 1'b0;
      mem_wr_req = 1'b0;
      running    = 1'b0;
      case (state_q)
         ST_RUN: begin
            running = 1'b1;
            retire  = !need_rd && !need_wr;
         end
         ST_RD_WAIT: begin
            running    = 1'b1;
            mem_rd_req = 1'b1;
            retire     = timer_reached && mem_ack && !need_wr;
         end
         ST_WR_WAIT: begin
            running    = 1'b1;
            mem_wr_req = 1'b1;
            retire     = timer_reached && mem_ack;
         end
         default: ;
      endcase
      // A reset arriving mid-wait must not leak a retire pulse.
      retire                    = retire && resetn;
      program_counter_increment = retire && dec_increment;
      alu_load_src              = retire ? dec_load_src : 2'b00;
   end

   assign steps_left = steps_q;
   assign state_dbg  = state_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed bench for exec_sequencer: per-cycle vector table for run modes,
// plus hand sequences for memory waits, stop, halt and reset mid-wait.
module tb_exec_sequencer;

   localparam logic [15:0] I_ALU  = 16'h1234;
   localparam logic [15:0] I_HALT = 16'h0300;

   logic        clock = 1'b0;
   logic        resetn = 1'b0;
   logic        user_clock = 1'b1;
   logic        stop_req = 1'b0;
   logic [1:0]  run_mode = 2'b00;
   logic [7:0]  step_count = 8'd0;
   logic [15:0] current_instruction = I_ALU;
   logic [1:0]  dec_load_src = 2'b01;
   logic        dec_store = 1'b0;
   logic        dec_increment = 1'b1;
   logic        mem_ack = 1'b0;
   logic        program_counter_increment;
   logic [1:0]  alu_load_src;
   logic        mem_rd_req, mem_wr_req, running;
   logic [7:0]  steps_left;
   logic [2:0]  state_dbg;
   logic [13:0] outs;

   int n_vec = 0;
   int n_err = 0;
   logic [13:0] exp_q[$];

   exec_sequencer #(.RD_MIN(3), .WR_MIN(2), .CNT_W(4), .STEP_W(8), .HALT_OPCODE(16'h0300)) dut (
      .clock                     (clock),
      .resetn                    (resetn),
      .user_clock                (user_clock),
      .stop_req                  (stop_req),
      .run_mode                  (run_mode),
      .step_count                (step_count),
      .current_instruction       (current_instruction),
      .dec_load_src              (dec_load_src),
      .dec_store                 (dec_store),
      .dec_increment             (dec_increment),
      .mem_ack                   (mem_ack),
      .program_counter_increment (program_counter_increment),
      .alu_load_src              (alu_load_src),
      .mem_rd_req                (mem_rd_req),
      .mem_wr_req                (mem_wr_req),
      .running                   (running),
      .steps_left                (steps_left),
      .state_dbg                 (state_dbg)
   );

   always #5 clock = ~clock;

   assign outs = {program_counter_increment, alu_load_src, mem_rd_req, mem_wr_req, running, steps_left};

   typedef struct {
      logic        uc;
      logic        stop;
      logic [1:0]  mode;
      logic [7:0]  sc;
      logic [15:0] instr;
      logic [1:0]  src;
      logic        inc;
      logic        ack;
      logic [13:0] exp;
   } vec_t;

   vec_t tbl[28];

   function automatic logic [13:0] ex(input logic pc, input logic [1:0] alu, input logic rd,
                                      input logic wr, input logic run, input logic [7:0] st);
      return {pc, alu, rd, wr, run, st};
   endfunction

   function automatic vec_t mk(input logic uc, input logic stop, input logic [1:0] mode,
                               input logic [7:0] sc, input logic [15:0] instr, input logic [1:0] src,
                               input logic inc, input logic ack, input logic [13:0] e);
      vec_t v;
      v.uc = uc; v.stop = stop; v.mode = mode; v.sc = sc; v.instr = instr;
      v.src = src; v.inc = inc; v.ack = ack; v.exp = e;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s got=%h want=%h (state %0d)", nm, got, want, state_dbg);
      end
   endtask

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic press(input logic [1:0] mode);
      run_mode   = mode;
      user_clock = 1'b0;
      cyc();
      user_clock = 1'b1;
      cyc();
   endtask

   // Runs one instruction in free-run mode with a simple memory model that
   // acks once each request has been up for the given number of cycles.
   task automatic run_instr(input string nm, input logic [1:0] src, input logic st,
                            input logic [15:0] instr, input logic hold, input int rd_dly,
                            input int wr_dly, input logic stop_start, input logic stop_in_wr,
                            input int exp_rd, input int exp_wr, input logic [1:0] exp_src);
      int rd_n = 0, wr_n = 0, pulses = 0;
      logic early = 1'b0, done = 1'b0;
      logic [1:0] ret_src = 2'b00;
      dec_load_src = src; dec_store = st; current_instruction = instr; dec_increment = 1'b1;
      stop_req = 1'b0; mem_ack = 1'b0;
      press(2'b00);
      stop_req = stop_start;
      for (int c = 0; c < 40 && !done; c++) begin
         if (!running) done = 1'b1;
         else begin
            if (mem_rd_req) rd_n++;
            if (mem_wr_req) begin
               wr_n++;
               if (stop_in_wr) stop_req = 1'b1;
            end
            mem_ack = hold | (mem_rd_req && rd_n >= rd_dly) | (mem_wr_req && wr_n >= wr_dly);
            #1;
            if (program_counter_increment) begin
               pulses++;
               ret_src = alu_load_src;
            end else if (alu_load_src != 2'b00) early = 1'b1;
            cyc();
         end
      end
      chk({nm, "_ended_idle"}, 32'(done), 32'd1);
      chk({nm, "_rd_cycles"}, 32'(rd_n), 32'(exp_rd));
      chk({nm, "_wr_cycles"}, 32'(wr_n), 32'(exp_wr));
      chk({nm, "_pc_pulses"}, 32'(pulses), 32'd1);
      chk({nm, "_retire_src"}, 32'(ret_src), 32'(exp_src));
      chk({nm, "_early_src"}, 32'(early), 32'd0);
      stop_req = 1'b0; mem_ack = 1'b0; dec_store = 1'b0;
      current_instruction = I_ALU; dec_load_src = 2'b01;
   endtask

   initial begin
      tbl[0]  = mk(1, 0, 2'b00, 8'd0, I_ALU,  2'b01, 1, 0, ex(0, 2'b00, 0, 0, 0, 8'd0));
      tbl[1]  = mk(0, 0, 2'b00, 8'd0, I_ALU,  2'b01, 1, 0, ex(0, 2'b00, 0, 0, 0, 8'd0));
      tbl[2]  = mk(0, 0, 2'b00, 8'd0, I_ALU,  2'b01, 1, 0, ex(0, 2'b00, 0, 0, 0, 8'd0));
      tbl[3]  = mk(1, 0, 2'b00, 8'd0, I_ALU,  2'b01, 1, 0, ex(0, 2'b00, 0, 0, 0, 8'd0));
      tbl[4]  = mk(1, 0, 2'b00, 8'd0, I_ALU,  2'b01, 1, 1, ex(1, 2'b01, 0, 0, 1, 8'd0));
      tbl[5]  = mk(1, 0, 2'b00, 8'd0, I_ALU,  2'b00, 1, 0, ex(1, 2'b00, 0, 0, 1, 8'd0));
      tbl[6]  = mk(1, 0, 2'b00, 8'd0, I_ALU,  2'b01, 0, 0, ex(0, 2'b01, 0, 0, 1, 8'd0));
      tbl[7]  = mk(1, 1, 2'b00, 8'd0, I_ALU,  2'b01, 1, 0, ex(1, 2'b01, 0, 0, 1, 8'd0));
      tbl[8]  = mk(1, 0, 2'b00, 8'd0, I_ALU,  2'b01, 1, 0, ex(0, 2'b00, 0, 0, 0, 8'd0));
      tbl[9]  = mk(0, 0, 2'b10, 8'd4, I_ALU,  2'b01, 1, 0, ex(0, 2'b00, 0, 0, 0, 8'd0));
      tbl[10] = mk(1, 0, 2'b10, 8'd4, I_ALU,  2'b01, 1, 0, ex(0, 2'b00, 0, 0, 0, 8'd0));
      tbl[11] = mk(1, 0, 2'b10, 8'd4, I_ALU,  2'b01, 1, 0, ex(1, 2'b01, 0, 0, 1, 8'd4));
      tbl[12] = mk(1, 0, 2'b00, 8'd4, I_ALU,  2'b01, 1, 0, ex(1, 2'b01, 0, 0, 1, 8'd3));
      tbl[13] = mk(1, 0, 2'b01, 8'd4, I_ALU,  2'b01, 1, 0, ex(1, 2'b01, 0, 0, 1, 8'd2));
      tbl[14] = mk(1, 0, 2'b10, 8'd4, I_ALU,  2'b01, 1, 0, ex(1, 2'b01, 0, 0, 1, 8'd1));
      tbl[15] = mk(1, 0, 2'b10, 8'd4, I_ALU,  2'b01, 1, 0, ex(0, 2'b00, 0, 0, 0, 8'd0));
      tbl[16] = mk(0, 0, 2'b10, 8'd0, I_ALU,  2'b01, 1, 0, ex(0, 2'b00, 0, 0, 0, 8'd0));
      tbl[17] = mk(1, 0, 2'b10, 8'd0, I_ALU,  2'b01, 1, 0, ex(0, 2'b00, 0, 0, 0, 8'd0));
      tbl[18] = mk(1, 0, 2'b10, 8'd0, I_ALU,  2'b01, 1, 0, ex(1, 2'b01, 0, 0, 1, 8'd1));
      tbl[19] = mk(1, 0, 2'b10, 8'd0, I_ALU,  2'b01, 1, 0, ex(0, 2'b00, 0, 0, 0, 8'd0));
      tbl[20] = mk(0, 0, 2'b01, 8'd9, I_ALU,  2'b01, 1, 0, ex(0, 2'b00, 0, 0, 0, 8'd0));
      tbl[21] = mk(1, 0, 2'b01, 8'd9, I_ALU,  2'b01, 1, 0, ex(0, 2'b00, 0, 0, 0, 8'd0));
      tbl[22] = mk(1, 0, 2'b01, 8'd9, I_ALU,  2'b01, 1, 0, ex(1, 2'b01, 0, 0, 1, 8'd1));
      tbl[23] = mk(1, 0, 2'b01, 8'd9, I_ALU,  2'b01, 1, 0, ex(0, 2'b00, 0, 0, 0, 8'd0));
      tbl[24] = mk(0, 0, 2'b00, 8'd0, I_ALU,  2'b01, 1, 0, ex(0, 2'b00, 0, 0, 0, 8'd0));
      tbl[25] = mk(1, 0, 2'b00, 8'd0, I_ALU,  2'b01, 1, 0, ex(0, 2'b00, 0, 0, 0, 8'd0));
      tbl[26] = mk(1, 0, 2'b00, 8'd0, I_HALT, 2'b01, 1, 0, ex(1, 2'b01, 0, 0, 1, 8'd0));
      tbl[27] = mk(1, 0, 2'b00, 8'd0, I_ALU,  2'b01, 1, 0, ex(0, 2'b00, 0, 0, 0, 8'd0));

      resetn = 1'b0;
      repeat (2) cyc();
      chk("reset_outputs", 32'(outs), 32'd0);
      chk("reset_state", 32'(state_dbg), 32'd0);
      resetn = 1'b1;

      for (int i = 0; i < 28; i++) begin
         user_clock = tbl[i].uc;  stop_req = tbl[i].stop;  run_mode = tbl[i].mode;
         step_count = tbl[i].sc;  current_instruction = tbl[i].instr;
         dec_load_src = tbl[i].src; dec_increment = tbl[i].inc; mem_ack = tbl[i].ack;
         dec_store = 1'b0;
         #1;
         exp_q.push_back(tbl[i].exp);
         chk($sformatf("tbl[%0d]", i), 32'(outs), 32'(exp_q.pop_front()));
         cyc();
      end
      mem_ack = 1'b0; stop_req = 1'b0; dec_increment = 1'b1;

      run_instr("rd_hold",  2'b10, 1'b0, I_ALU,  1'b1, 1, 1, 1'b1, 1'b0, 3, 0, 2'b10);
      run_instr("rd_wr_5",  2'b10, 1'b1, I_ALU,  1'b0, 5, 5, 1'b1, 1'b0, 5, 5, 2'b10);
      run_instr("wr_stop",  2'b01, 1'b1, I_ALU,  1'b0, 1, 4, 1'b0, 1'b1, 0, 4, 2'b01);
      run_instr("wr_min",   2'b00, 1'b1, I_ALU,  1'b1, 1, 1, 1'b1, 1'b0, 0, 2, 2'b00);
      run_instr("halt_rd",  2'b11, 1'b0, I_HALT, 1'b1, 1, 1, 1'b0, 1'b0, 3, 0, 2'b11);

      // Reset while the read is pending and its completion conditions are met.
      dec_load_src = 2'b10; dec_store = 1'b0; mem_ack = 1'b0; stop_req = 1'b0;
      press(2'b00);
      repeat (3) cyc();
      chk("rst_rd_pending", 32'(mem_rd_req), 32'd1);
      resetn = 1'b0;
      mem_ack = 1'b1;
      #1;
      chk("rst_no_pc_pulse", 32'(program_counter_increment), 32'd0);
      chk("rst_no_load_src", 32'(alu_load_src), 32'd0);
      cyc();
      chk("rst_after_outputs", 32'(outs), 32'd0);
      chk("rst_after_state", 32'(state_dbg), 32'd0);
      resetn = 1'b1; mem_ack = 1'b0;
      cyc();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
